one_wire_gc_host: RTL and testbench
===================================

Name: one_wire_gc_host

Overview:
- Console-side initiator for the GameCube one-wire controller bus.
- Serialises a command of 1–24 bits onto the bus, sends the stop bit, turns the bus around, then decodes the controller's response bits into a parallel buffer.
- Sits between a host-side poll scheduler and the bidirectional pad; the pad and its inout port live in the top module.
- Primary use: bench/debug master for the controller-side slave, and a console emulator for hardware-in-loop testing.

Parameters:
- CLKS_PER_US, 40: clock cycles per microsecond (40 MHz clock).
- RSP_WIDTH, 80: response buffer width in bits (up to a 10-byte response).
- TIMEOUT_US, 100: maximum wait, in microseconds, for the first response falling edge.
- GUARD_CLKS, 10: cycles after bus release before RX sampling begins (pad turnaround).

Ports:
- CLK  in  1  clock, 40 MHz.
- RESET  in  1  reset, synchronous, active-low.
- START  in  1  one-cycle request; sampled only in IDLE.
- CMD  in  24  command bits; first transmitted bit is CMD[23], then descending.
- CMD_BITS  in  5  number of command bits to send (1–24).
- RSP_BITS  in  7  expected response bits (0–RSP_WIDTH).
- GC_BUS_IN  in  1  raw bus level from the pad.
- GC_BUS_OUT  out  1  0 = drive low; 1 = release (pull-up).
- BUSY  out  1  high from accepted START until DONE.
- DONE  out  1  one-cycle pulse at transaction end.
- TIMEOUT_ERR  out  1  valid with DONE: no response, or response truncated or malformed.
- RSP  out  RSP_WIDTH  received bits; first received bit at RSP[RSP_WIDTH-1].
- RSP_COUNT  out  7  number of response bits actually received.

Behaviour:
- Reset values (RESET=0 at any clock edge, including mid-transaction):
  - GC_BUS_OUT=1, BUSY=0, DONE=0, TIMEOUT_ERR=0, RSP=0, RSP_COUNT=0.
  - State goes to IDLE and all counters clear.
- Input sync: GC_BUS_IN passes through a 2-FF synchroniser. All edge detection uses the synchronised level, so there is 2 cycles of latency.
- Bit cell is 4*CLKS_PER_US cycles:
  - '1' = low for CLKS_PER_US, then high for 3*CLKS_PER_US.
  - '0' = low for 3*CLKS_PER_US, then high for CLKS_PER_US.
- States:
  - IDLE: GC_BUS_OUT=1.
    - START && CMD_BITS!=0: latch CMD, CMD_BITS, and min(RSP_BITS, RSP_WIDTH); clear RSP and RSP_COUNT; BUSY=1; go to TX_LOW.
    - START with CMD_BITS==0: ignored, no DONE.
  - TX_LOW: GC_BUS_OUT=0 for the low time of the current bit, then go to TX_HIGH. The first low cycle is the cycle after START.
  - TX_HIGH: GC_BUS_OUT=1 for the high time. Then decrement the bit count: if bits remain, go to TX_LOW; otherwise go to STOP_LOW.
  - STOP_LOW: GC_BUS_OUT=0 for CLKS_PER_US, then release and go to GUARD.
  - GUARD: wait GUARD_CLKS cycles.
    - If the latched RSP_BITS==0: assert DONE (TIMEOUT_ERR=0) and go to IDLE.
    - Otherwise go to RX_WAIT.
  - RX_WAIT:
    - A falling edge goes to RX_LOW and clears the low counter.
    - No falling edge within TIMEOUT_US*CLKS_PER_US cycles: DONE with TIMEOUT_ERR=1, RSP_COUNT=0.
  - RX_LOW: count synchronised-low cycles.
    - On a rising edge with count < 2*CLKS_PER_US the bit is 1; otherwise it is 0.
    - Store the bit at RSP[RSP_WIDTH-1-RSP_COUNT] and increment RSP_COUNT.
    - If RSP_COUNT has reached the latched RSP_BITS, go to RX_STOP; otherwise go to RX_HIGH.
    - Low held longer than 5*CLKS_PER_US: DONE with TIMEOUT_ERR=1.
  - RX_HIGH:
    - A falling edge goes to RX_LOW.
    - High for longer than 2 bit cells (8*CLKS_PER_US): truncated response, DONE with TIMEOUT_ERR=1 and RSP_COUNT equal to the bits received.
  - RX_STOP: wait for the stop bit's falling then rising edge.
    - Stop bit completes: DONE with TIMEOUT_ERR=0.
    - Stop bit missing for 8*CLKS_PER_US: DONE with TIMEOUT_ERR=0; the stop bit is tolerated.
- DONE, TIMEOUT_ERR, and the transition to IDLE occur in the same cycle. BUSY falls in that cycle. TIMEOUT_ERR holds until the next accepted START.
- GC_BUS_OUT is never 0 outside the TX_LOW and STOP_LOW states.
- START while BUSY is ignored.
- RSP_COUNT saturates at the latched RSP_BITS; extra bits are never written.

Decomposition:
- Shared package one_wire_gc_pkg:
  - State encoding.
  - Timing constants derived from CLKS_PER_US: T1US, T2US, T3US, T4US, T5US, T8US.
  - Command codes: PROBE 8'h00, ORIGIN 8'h41, POLL 24'h400300.
- One natural sub-module, one_wire_gc_bit_decoder:
  - Contains the synchroniser, the edge detector, and the low-pulse width classifier.
  - Outputs bit_valid/bit_value pulses, stall-timeout flags, and an edge_fall pulse.

Test Plan:
- Poll: CMD=24'h400300, CMD_BITS=24, RSP_BITS=64; responder returns 64'h0080_8080_8080_0000.
  - Bus shows bit 0 low 120 / high 40, and bit 1 low 40 / high 120.
  - Stop low is 40 cycles.
  - DONE=1, TIMEOUT_ERR=0, RSP[79:16]=64'h0080808080800000, RSP_COUNT=64.
- Probe: CMD=24'h000000, CMD_BITS=8, RSP_BITS=24; responder returns 24'h090000.
  - Exactly 8 cells plus the stop bit are driven.
  - RSP[79:56]=24'h090000, RSP_COUNT=24.
- No responder: DONE arrives 4000 cycles after GUARD (±2) with TIMEOUT_ERR=1 and RSP_COUNT=0.
- Truncated response: responder stops after 16 of 64 bits, giving DONE with TIMEOUT_ERR=1 and RSP_COUNT=16.
- Second START while BUSY: ignored, no change to the bus waveform. RESET=0 mid-TX_LOW: GC_BUS_OUT=1 the next cycle, BUSY=0, and no DONE.
- RSP_BITS=0 with CMD_BITS=8: DONE exactly GUARD_CLKS cycles after stop-bit release, with TIMEOUT_ERR=0.

Source files
------------

// File: rtl/one_wire_gc_pkg.sv
// Shared definitions for the GameCube one-wire host: state encoding, bus timing
// constants at the default 40 MHz clock, and well-known command codes.
package one_wire_gc_pkg;

    localparam int GC_CLKS_PER_US = 40;
    localparam int T1US = GC_CLKS_PER_US;
    localparam int T2US = 2 * GC_CLKS_PER_US;
    localparam int T3US = 3 * GC_CLKS_PER_US;
    localparam int T4US = 4 * GC_CLKS_PER_US;
    localparam int T5US = 5 * GC_CLKS_PER_US;
    localparam int T8US = 8 * GC_CLKS_PER_US;

    localparam logic [7:0]  CMD_PROBE  = 8'h00;
    localparam logic [7:0]  CMD_ORIGIN = 8'h41;
    localparam logic [23:0] CMD_POLL   = 24'h400300;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_TX_LOW   = 4'd1,
        ST_TX_HIGH  = 4'd2,
        ST_STOP_LOW = 4'd3,
        ST_GUARD    = 4'd4,
        ST_RX_WAIT  = 4'd5,
        ST_RX_LOW   = 4'd6,
        ST_RX_HIGH  = 4'd7,
        ST_RX_STOP  = 4'd8
    } gc_state_e;

    // Low time of a transmitted bit cell; the high time is the rest of the 4 us cell.
    function automatic int tx_low_clks(input logic bit_val, input int clks_per_us);
        return bit_val ? clks_per_us : 3 * clks_per_us;
    endfunction

endpackage

// File: rtl/one_wire_gc_bit_decoder.sv
// Receive front end: 2-FF synchroniser, edge detector, low-pulse classifier and
// stall detectors for the one-wire bus.
module one_wire_gc_bit_decoder #(
    parameter int CLKS_PER_US = 40
) (
    input  logic CLK,
    input  logic RESET,
    input  logic bus_in,
    output logic edge_fall,
    output logic bit_valid,
    output logic bit_value,
    output logic low_stall,
    output logic high_stall
);

    localparam logic [15:0] T2_C  = 16'(2 * CLKS_PER_US);
    localparam logic [15:0] T5_C  = 16'(5 * CLKS_PER_US);
    localparam logic [15:0] T8_C  = 16'(8 * CLKS_PER_US);
    localparam logic [15:0] SAT_C = 16'hFFFF;

    logic [1:0]  sync_q, sync_d;
    logic        lvl_q, lvl_d;
    logic [15:0] low_cnt_q, low_cnt_d;
    logic [15:0] high_cnt_q, high_cnt_d;
    logic        level_s, edge_rise_s;

    // Edge detection and run-length counting on the synchronised level.
    always_comb begin
        sync_d      = {sync_q[0], bus_in};
        level_s     = sync_q[1];
        lvl_d       = level_s;
        edge_fall   = lvl_q & ~level_s;
        edge_rise_s = ~lvl_q & level_s;

        if (edge_fall) begin
            low_cnt_d = 16'd1;
        end else if (!level_s && (low_cnt_q != SAT_C)) begin
            low_cnt_d = low_cnt_q + 16'd1;
        end else begin
            low_cnt_d = low_cnt_q;
        end

        if (edge_rise_s) begin
            high_cnt_d = 16'd1;
        end else if (level_s && (high_cnt_q != SAT_C)) begin
            high_cnt_d = high_cnt_q + 16'd1;
        end else begin
            high_cnt_d = high_cnt_q;
        end

        bit_valid  = edge_rise_s;
        bit_value  = (low_cnt_q < T2_C);
        low_stall  = ~level_s & (low_cnt_q >= T5_C);
        high_stall = level_s & (high_cnt_q >= T8_C);
    end

    // Synchroniser and counter registers; the bus idles high.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            sync_q     <= 2'b11;
            lvl_q      <= 1'b1;
            low_cnt_q  <= 16'd0;
            high_cnt_q <= 16'd0;
        end else begin
            sync_q     <= sync_d;
            lvl_q      <= lvl_d;
            low_cnt_q  <= low_cnt_d;
            high_cnt_q <= high_cnt_d;
        end
    end

endmodule

// File: rtl/one_wire_gc_host.sv
// Console-side GameCube one-wire initiator: sends a 1-24 bit command plus stop
// bit, releases the bus, then collects the controller response into RSP.
module one_wire_gc_host
    import one_wire_gc_pkg::*;
#(
    parameter int CLKS_PER_US = GC_CLKS_PER_US,
    parameter int RSP_WIDTH   = 80,
    parameter int TIMEOUT_US  = 100,
    parameter int GUARD_CLKS  = 10
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic [23:0]          CMD,
    input  logic [4:0]           CMD_BITS,
    input  logic [6:0]           RSP_BITS,
    input  logic                 GC_BUS_IN,
    output logic                 GC_BUS_OUT,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 TIMEOUT_ERR,
    output logic [RSP_WIDTH-1:0] RSP,
    output logic [6:0]           RSP_COUNT
);

    localparam int          IDX_W   = $clog2(RSP_WIDTH);
    localparam logic [15:0] T1_C    = 16'(CLKS_PER_US);
    localparam logic [15:0] CELL_C  = 16'(4 * CLKS_PER_US);
    localparam logic [15:0] T8_C    = 16'(8 * CLKS_PER_US);
    localparam logic [15:0] TO_C    = 16'(TIMEOUT_US * CLKS_PER_US);
    localparam logic [15:0] GUARD_C = 16'(GUARD_CLKS);

    gc_state_e            state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [23:0]          cmd_q, cmd_d;
    logic [4:0]           bits_q, bits_d;
    logic [6:0]           rsp_bits_q, rsp_bits_d;
    logic [RSP_WIDTH-1:0] rsp_q, rsp_d;
    logic [6:0]           rsp_count_q, rsp_count_d;
    logic                 bus_out_q, bus_out_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [15:0]          low_len_s, high_len_s;
    logic [IDX_W-1:0]     rsp_idx_s;
    logic                 edge_fall_s, bit_valid_s, bit_value_s, low_stall_s, high_stall_s;

    one_wire_gc_bit_decoder #(
        .CLKS_PER_US (CLKS_PER_US)
    ) u_decoder (
        .CLK        (CLK),
        .RESET      (RESET),
        .bus_in     (GC_BUS_IN),
        .edge_fall  (edge_fall_s),
        .bit_valid  (bit_valid_s),
        .bit_value  (bit_value_s),
        .low_stall  (low_stall_s),
        .high_stall (high_stall_s)
    );

    // Transaction sequencing; bus drive, BUSY and DONE follow the next state so they are registered.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        bits_d      = bits_q;
        rsp_bits_d  = rsp_bits_q;
        rsp_d       = rsp_q;
        rsp_count_d = rsp_count_q;
        done_d      = 1'b0;
        err_d       = err_q;
        low_len_s   = 16'(tx_low_clks(cmd_q[23], CLKS_PER_US));
        high_len_s  = CELL_C - low_len_s;
        rsp_idx_s   = IDX_W'(RSP_WIDTH - 1 - int'(rsp_count_q));

        case (state_q)
            ST_IDLE: begin
                if (START && (CMD_BITS != 5'd0)) begin
                    cmd_d       = CMD;
                    bits_d      = (CMD_BITS > 5'd24) ? 5'd24 : CMD_BITS;
                    rsp_bits_d  = (int'(RSP_BITS) > RSP_WIDTH) ? 7'(RSP_WIDTH) : RSP_BITS;
                    rsp_d       = '0;
                    rsp_count_d = 7'd0;
                    err_d       = 1'b0;
                    cnt_d       = 16'd0;
                    state_d     = ST_TX_LOW;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TX_LOW: begin
                if (cnt_q == low_len_s - 16'd1) begin
                    cnt_d   = 16'd0;
                    state_d = ST_TX_HIGH;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_TX_HIGH: begin
                if (cnt_q == high_len_s - 16'd1) begin
                    cnt_d   = 16'd0;
                    cmd_d   = {cmd_q[22:0], 1'b0};
                    bits_d  = bits_q - 5'd1;
                    state_d = (bits_q == 5'd1) ? ST_STOP_LOW : ST_TX_LOW;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_STOP_LOW: begin
                if (cnt_q == T1_C - 16'd1) begin
                    cnt_d   = 16'd0;
                    state_d = ST_GUARD;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_GUARD: begin
                if (cnt_q == GUARD_C - 16'd1) begin
                    cnt_d = 16'd0;
                    if (rsp_bits_q == 7'd0) begin
                        done_d  = 1'b1;
                        err_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RX_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RX_WAIT: begin
                if (edge_fall_s) begin
                    state_d = ST_RX_LOW;
                end else if (cnt_q == TO_C - 16'd1) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RX_LOW: begin
                if (bit_valid_s) begin
                    rsp_d[rsp_idx_s] = bit_value_s;
                    rsp_count_d      = rsp_count_q + 7'd1;
                    cnt_d            = 16'd0;
                    state_d          = (rsp_count_d == rsp_bits_q) ? ST_RX_STOP : ST_RX_HIGH;
                end else if (low_stall_s) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RX_LOW;
                end
            end
            ST_RX_HIGH: begin
                if (edge_fall_s) begin
                    state_d = ST_RX_LOW;
                end else if (high_stall_s) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RX_HIGH;
                end
            end
            ST_RX_STOP: begin
                // A missing stop bit is tolerated: the data is already complete.
                if (bit_valid_s || (cnt_q == T8_C - 16'd1)) begin
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        bus_out_d = !((state_d == ST_TX_LOW) || (state_d == ST_STOP_LOW));
        busy_d    = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            cmd_q       <= 24'd0;
            bits_q      <= 5'd0;
            rsp_bits_q  <= 7'd0;
            rsp_q       <= '0;
            rsp_count_q <= 7'd0;
            bus_out_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            bits_q      <= bits_d;
            rsp_bits_q  <= rsp_bits_d;
            rsp_q       <= rsp_d;
            rsp_count_q <= rsp_count_d;
            bus_out_q   <= bus_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign GC_BUS_OUT  = bus_out_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign TIMEOUT_ERR = err_q;
    assign RSP         = rsp_q;
    assign RSP_COUNT   = rsp_count_q;

endmodule

// File: tb/tb_one_wire_gc_host.sv
// Self-checking bench for one_wire_gc_host: a wired-AND bus with a behavioural
// controller responder, checked against a bit-cell level reference model.
`timescale 1ns/1ps
module tb_one_wire_gc_host;
    import one_wire_gc_pkg::*;

    localparam int RW    = 80;
    localparam int GUARD = 10;
    localparam int CELL  = T4US;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic [23:0] CMD = 24'd0;
    logic [4:0]  CMD_BITS = 5'd0;
    logic [6:0]  RSP_BITS = 7'd0;
    logic        rsp_drv = 1'b1;
    logic        bus_s;
    logic        GC_BUS_OUT, BUSY, DONE, TIMEOUT_ERR;
    logic [RW-1:0] RSP;
    logic [6:0]  RSP_COUNT;

    assign bus_s = GC_BUS_OUT & rsp_drv;

    one_wire_gc_host #(
        .CLKS_PER_US (GC_CLKS_PER_US),
        .RSP_WIDTH   (RW),
        .TIMEOUT_US  (100),
        .GUARD_CLKS  (GUARD)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .START       (START),
        .CMD         (CMD),
        .CMD_BITS    (CMD_BITS),
        .RSP_BITS    (RSP_BITS),
        .GC_BUS_IN   (bus_s),
        .GC_BUS_OUT  (GC_BUS_OUT),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .TIMEOUT_ERR (TIMEOUT_ERR),
        .RSP         (RSP),
        .RSP_COUNT   (RSP_COUNT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Record every host-side bus transition and every DONE pulse.
    int   tx_cyc_q[$];
    logic tx_lvl_q[$];
    int   done_cyc_q[$];
    logic done_err_q[$];
    logic done_busy_q[$];
    logic bus_prev = 1'b1;
    always @(negedge CLK) begin
        if (GC_BUS_OUT !== bus_prev) begin
            tx_cyc_q.push_back(cyc);
            tx_lvl_q.push_back(GC_BUS_OUT);
        end
        bus_prev = GC_BUS_OUT;
        if (DONE === 1'b1) begin
            done_cyc_q.push_back(cyc);
            done_err_q.push_back(TIMEOUT_ERR);
            done_busy_q.push_back(BUSY);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic clear_mon();
        tx_cyc_q.delete();
        tx_lvl_q.delete();
        done_cyc_q.delete();
        done_err_q.delete();
        done_busy_q.delete();
    endtask

    // One full transaction: drive the command, optionally answer, compare with the model.
    task automatic run_txn(input logic [23:0] cmd, input int nbits, input int rbits,
                           input logic [79:0] pat, input int nsend, input bit stop_bit,
                           input bit extra_start, input string tag);
        int   k0, t, lo, exp_r, rb, exp_cnt, lim, d, n;
        logic exp_err;
        logic [79:0] mask, exp_rsp;
        int   exp_cyc[$];
        logic exp_lvl[$];

        @(negedge CLK);
        START = 1'b1; CMD = cmd; CMD_BITS = 5'(nbits); RSP_BITS = 7'(rbits);
        k0 = cyc + 1;
        clear_mon();
        @(negedge CLK);
        START = 1'b0;
        check_eq({tag, "_busy"}, 96'(BUSY), 96'd1);

        t = k0;
        for (int i = 0; i < nbits; i++) begin
            lo = cmd[23 - i] ? T1US : T3US;
            exp_cyc.push_back(t);      exp_lvl.push_back(1'b0);
            exp_cyc.push_back(t + lo); exp_lvl.push_back(1'b1);
            t += CELL;
        end
        exp_cyc.push_back(t);        exp_lvl.push_back(1'b0);
        exp_cyc.push_back(t + T1US); exp_lvl.push_back(1'b1);
        exp_r = t + T1US;

        if (extra_start) begin
            repeat (150) @(negedge CLK);
            START = 1'b1; CMD = ~cmd; CMD_BITS = 5'd24;
            @(negedge CLK);
            START = 1'b0;
            check_eq({tag, "_busy_mid"}, 96'(BUSY), 96'd1);
        end

        lim = 0;
        while (tx_cyc_q.size() < exp_cyc.size() && lim < nbits * CELL + 400) begin
            @(negedge CLK);
            lim++;
        end
        check_eq({tag, "_tx_edges"}, 96'(tx_cyc_q.size()), 96'(exp_cyc.size()));
        n = (tx_cyc_q.size() < exp_cyc.size()) ? tx_cyc_q.size() : exp_cyc.size();
        for (int i = 0; i < n; i++)
            check_eq({tag, "_tx_edge"}, 96'({tx_lvl_q[i], 32'(tx_cyc_q[i])}),
                     96'({exp_lvl[i], 32'(exp_cyc[i])}));

        if (nsend > 0) begin
            d = int'($urandom_range(20, 80));
            repeat (d) @(negedge CLK);
            for (int i = 0; i < nsend; i++) begin
                lo = pat[79 - i] ? int'($urandom_range(32, 48)) : int'($urandom_range(110, 130));
                rsp_drv = 1'b0;
                repeat (lo) @(negedge CLK);
                rsp_drv = 1'b1;
                repeat (CELL - lo) @(negedge CLK);
            end
            if (stop_bit) begin
                rsp_drv = 1'b0;
                repeat (T1US) @(negedge CLK);
                rsp_drv = 1'b1;
            end
        end

        rb = (rbits > RW) ? RW : rbits;
        if (rb == 0)          begin exp_err = 1'b0; exp_cnt = 0;     end
        else if (nsend == 0)  begin exp_err = 1'b1; exp_cnt = 0;     end
        else if (nsend < rb)  begin exp_err = 1'b1; exp_cnt = nsend; end
        else                  begin exp_err = 1'b0; exp_cnt = rb;    end
        mask    = (exp_cnt == 0) ? 80'd0 : ~({80{1'b1}} >> exp_cnt);
        exp_rsp = pat & mask;

        lim = 0;
        while (done_cyc_q.size() == 0 && lim < 6000) begin
            @(negedge CLK);
            lim++;
        end
        if (done_cyc_q.size() == 0) begin
            check_eq({tag, "_done_seen"}, 96'd0, 96'd1);
        end else begin
            repeat (4) @(negedge CLK);
            check_eq({tag, "_done_pulses"}, 96'(done_cyc_q.size()), 96'd1);
            check_eq({tag, "_err"}, 96'(done_err_q[0]), 96'(exp_err));
            check_eq({tag, "_busy_at_done"}, 96'(done_busy_q[0]), 96'd0);
            check_eq({tag, "_rsp"}, 96'(RSP), 96'(exp_rsp));
            check_eq({tag, "_rsp_count"}, 96'(RSP_COUNT), 96'(exp_cnt));
            check_eq({tag, "_err_hold"}, 96'(TIMEOUT_ERR), 96'(exp_err));
            if (rb == 0)
                check_eq({tag, "_done_lat"}, 96'(done_cyc_q[0] - exp_r), 96'(GUARD));
            else if (nsend == 0)
                check_eq({tag, "_timeout_lat_ok"},
                         96'((done_cyc_q[0] - exp_r - GUARD >= 3998) &&
                             (done_cyc_q[0] - exp_r - GUARD <= 4002)), 96'd1);
        end
        repeat (20) @(negedge CLK);
    endtask

    logic [95:0] rnd;
    int          nb, rbr;

    initial begin
        repeat (3) @(negedge CLK);
        check_eq("rst_bus", 96'(GC_BUS_OUT), 96'd1);
        check_eq("rst_busy", 96'(BUSY), 96'd0);
        check_eq("rst_done", 96'(DONE), 96'd0);
        check_eq("rst_err", 96'(TIMEOUT_ERR), 96'd0);
        check_eq("rst_rsp", 96'(RSP), 96'd0);
        check_eq("rst_count", 96'(RSP_COUNT), 96'd0);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);

        // Zero-length command is ignored.
        clear_mon();
        START = 1'b1; CMD = CMD_POLL; CMD_BITS = 5'd0; RSP_BITS = 7'd8;
        @(negedge CLK);
        START = 1'b0;
        repeat (30) @(negedge CLK);
        check_eq("zero_bits_busy", 96'(BUSY), 96'd0);
        check_eq("zero_bits_done", 96'(done_cyc_q.size()), 96'd0);
        check_eq("zero_bits_bus", 96'(tx_cyc_q.size()), 96'd0);

        run_txn(CMD_POLL, 24, 64, {64'h0080_8080_8080_0000, 16'h0}, 64, 1'b1, 1'b0, "poll");
        run_txn({CMD_PROBE, 16'h0}, 8, 24, {24'h090000, 56'h0}, 24, 1'b1, 1'b1, "probe");
        run_txn({CMD_ORIGIN, 16'h0}, 8, 24, 80'd0, 0, 1'b0, 1'b0, "noresp");
        rnd = {$urandom(), $urandom(), $urandom()};
        run_txn(CMD_POLL, 24, 64, rnd[95:16], 16, 1'b0, 1'b0, "trunc");
        run_txn({CMD_PROBE, 16'h0}, 8, 0, 80'd0, 0, 1'b0, 1'b0, "rsp0");
        rnd = {$urandom(), $urandom(), $urandom()};
        run_txn(rnd[23:0], 1, 100, rnd[95:16], 80, 1'b1, 1'b0, "clamp");

        // Reset in the middle of the first low phase.
        clear_mon();
        START = 1'b1; CMD = CMD_POLL; CMD_BITS = 5'd24; RSP_BITS = 7'd64;
        @(negedge CLK);
        START = 1'b0;
        repeat (20) @(negedge CLK);
        check_eq("midrst_pre_bus", 96'(GC_BUS_OUT), 96'd0);
        RESET = 1'b0;
        @(negedge CLK);
        check_eq("midrst_bus", 96'(GC_BUS_OUT), 96'd1);
        check_eq("midrst_busy", 96'(BUSY), 96'd0);
        check_eq("midrst_done", 96'(DONE), 96'd0);
        check_eq("midrst_count", 96'(RSP_COUNT), 96'd0);
        RESET = 1'b1;
        repeat (200) @(negedge CLK);
        check_eq("midrst_no_done", 96'(done_cyc_q.size()), 96'd0);
        check_eq("midrst_idle_bus", 96'(GC_BUS_OUT), 96'd1);

        for (int k = 0; k < 3; k++) begin
            rnd = {$urandom(), $urandom(), $urandom()};
            nb  = int'($urandom_range(1, 12));
            rbr = int'($urandom_range(1, 16));
            run_txn(rnd[23:0], nb, rbr, rnd[95:16], rbr, 1'($urandom_range(0, 1)), 1'b0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
